// File: rtl/rf_stage_pkg.sv
// rf_stage_pkg: default widths and the latched field bundle of the register-fetch stage
package rf_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_ID_W = 5;
  localparam int DEF_FLAG_W = 8;
  localparam int DEF_OPC_W = 6;
  localparam int DEF_PC_W = 16;
  typedef struct packed {
    logic valid;
    logic [DEF_OPC_W-1:0] opcode;
    logic [DEF_REG_ID_W-1:0] wr_id;
    logic [DEF_FLAG_W-1:0] fmask;
    logic [DEF_DATA_W-1:0] imm;
    logic eoi;
    logic [DEF_DATA_W-1:0] rd0_data;
    logic [DEF_REG_ID_W-1:0] rd0_id;
    logic [DEF_DATA_W-1:0] rd1_data;
    logic [DEF_REG_ID_W-1:0] rd1_id;
    logic [DEF_FLAG_W-1:0] flags;
    logic [DEF_PC_W-1:0] seq_npc;
  } rf_fields_t;
endpackage

// File: rtl/rf_stage_if.sv
// rf_stage_if: decoded instruction in from the translator, EXE pipeline register out
interface rf_stage_if
  import rf_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_ID_W = DEF_REG_ID_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int PC_W = DEF_PC_W
);
  logic in_valid, in_fread, in_eoi;
  logic [OPC_W-1:0] in_opcode;
  logic [2:0] in_len;
  logic [REG_ID_W-1:0] in_rd0_id, in_rd1_id, in_wr_id;
  logic [FLAG_W-1:0] in_fmask;
  logic [DATA_W-1:0] in_imm;
  logic out_valid, out_eoi;
  logic [OPC_W-1:0] out_opcode;
  logic [REG_ID_W-1:0] out_wr_id, out_rd0_id, out_rd1_id;
  logic [FLAG_W-1:0] out_fmask, out_flags;
  logic [DATA_W-1:0] out_imm, out_rd0_data, out_rd1_data;
  logic [PC_W-1:0] out_seq_npc;
  modport master (
    output in_valid, in_fread, in_eoi, in_opcode, in_len, in_rd0_id, in_rd1_id, in_wr_id, in_fmask, in_imm,
    input out_valid, out_eoi, out_opcode, out_wr_id, out_rd0_id, out_rd1_id, out_fmask, out_flags,
          out_imm, out_rd0_data, out_rd1_data, out_seq_npc
  );
  modport slave (
    input in_valid, in_fread, in_eoi, in_opcode, in_len, in_rd0_id, in_rd1_id, in_wr_id, in_fmask, in_imm,
    output out_valid, out_eoi, out_opcode, out_wr_id, out_rd0_id, out_rd1_id, out_fmask, out_flags,
           out_imm, out_rd0_data, out_rd1_data, out_seq_npc
  );
endinterface

// File: rtl/rf_stage_param_regfile.sv
// rf_regfile: 2R/1W register file plus flag register; RF_BYPASS_EN makes reads write-through
module rf_regfile
  import rf_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_ID_W = DEF_REG_ID_W,
  parameter int FLAG_W = DEF_FLAG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic [REG_ID_W-1:0] rd0_id,
  input  logic [REG_ID_W-1:0] rd1_id,
  input  logic [REG_ID_W-1:0] wr_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAG_W-1:0] fmask,
  input  logic [FLAG_W-1:0] fvals,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic [FLAG_W-1:0] flags
);
  logic [DATA_W-1:0] regs [2**REG_ID_W];
  logic [FLAG_W-1:0] flag_q, flag_nx;
  assign flag_nx = (flag_q & ~fmask) | (fvals & fmask);
  // register 0 is never written, so it reads 0 without a special case
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2**REG_ID_W; i++) regs[i] <= '0;
      flag_q <= '0;
    end else begin
      if (wr_id != '0) regs[wr_id] <= wr_data;
      flag_q <= flag_nx;
    end
`ifdef RF_BYPASS_EN
  assign rd0_data = (wr_id != '0 && wr_id == rd0_id) ? wr_data : regs[rd0_id];
  assign rd1_data = (wr_id != '0 && wr_id == rd1_id) ? wr_data : regs[rd1_id];
  assign flags = flag_nx;
`else
  assign rd0_data = regs[rd0_id];
  assign rd1_data = regs[rd1_id];
  assign flags = flag_q;
`endif
endmodule

// File: rtl/rf_stage_param.sv
// rf_stage_param: register-fetch stage with hazard bubbles, fetch PC and EXE register; RF_BYPASS_EN selects write-through reads
module rf_stage_param
  import rf_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_ID_W = DEF_REG_ID_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int PC_W = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic CLK,
  input  logic RST,
  rf_stage_if.slave rf,
  input  logic mem_pipe_stall,
  input  logic flush1,
  input  logic PCupdate,
  input  logic [PC_W-1:0] EXE_targetPC,
  input  logic [REG_ID_W-1:0] wb_wr_id,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [FLAG_W-1:0] wb_fmask,
  input  logic [FLAG_W-1:0] wb_flags,
  output logic [PC_W-1:0] fetch_pc,
  output logic bubble,
  output logic pipe_stall
);
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic [FLAG_W-1:0] flags_rd;
  logic exe_hit, wb_hit;
  rf_regfile #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .FLAG_W(FLAG_W)) u_regfile (
    .clk(CLK), .rst(RST),
    .rd0_id(rf.in_rd0_id), .rd1_id(rf.in_rd1_id),
    .wr_id(wb_wr_id), .wr_data(wb_result),
    .fmask(wb_fmask), .fvals(wb_flags),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .flags(flags_rd)
  );
  assign exe_hit = rf.out_valid & ((rf.out_wr_id != '0 & (rf.out_wr_id == rf.in_rd0_id | rf.out_wr_id == rf.in_rd1_id))
                                   | (rf.out_fmask != '0 & rf.in_fread));
`ifdef RF_BYPASS_EN
  assign wb_hit = 1'b0;
`else
  // without bypass a same-cycle write-back would be read stale, so wait one cycle
  assign wb_hit = (rf.in_valid & wb_wr_id != '0 & (wb_wr_id == rf.in_rd0_id | wb_wr_id == rf.in_rd1_id))
                  | (wb_fmask != '0 & rf.in_fread);
`endif
  assign bubble = (rf.in_valid & exe_hit) | wb_hit;
  assign pipe_stall = mem_pipe_stall | bubble;
  always_ff @(posedge CLK or posedge RST)
    if (RST) fetch_pc <= RESET_PC;
    else if (PCupdate) fetch_pc <= EXE_targetPC;
    else if (rf.in_valid & ~pipe_stall) fetch_pc <= fetch_pc + PC_W'(rf.in_len);
  // a bubble still loads the data fields; only valid/wr_id/fmask must be cleared
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rf.out_valid <= 1'b0;
      rf.out_opcode <= '0;
      rf.out_wr_id <= '0;
      rf.out_fmask <= '0;
      rf.out_imm <= '0;
      rf.out_eoi <= 1'b0;
      rf.out_rd0_data <= '0;
      rf.out_rd0_id <= '0;
      rf.out_rd1_data <= '0;
      rf.out_rd1_id <= '0;
      rf.out_flags <= '0;
      rf.out_seq_npc <= '0;
    end else if (flush1) rf.out_valid <= 1'b0;
    else if (!mem_pipe_stall) begin
      rf.out_valid <= rf.in_valid & ~bubble;
      rf.out_wr_id <= bubble ? '0 : rf.in_wr_id;
      rf.out_fmask <= bubble ? '0 : rf.in_fmask;
      rf.out_opcode <= rf.in_opcode;
      rf.out_imm <= rf.in_imm;
      rf.out_eoi <= rf.in_eoi;
      rf.out_rd0_data <= rd0_data;
      rf.out_rd0_id <= rf.in_rd0_id;
      rf.out_rd1_data <= rd1_data;
      rf.out_rd1_id <= rf.in_rd1_id;
      rf.out_flags <= flags_rd;
      rf.out_seq_npc <= fetch_pc + PC_W'(rf.in_len);
    end
endmodule

// File: tb/tb_rf_stage_param.sv
// tb_rf_stage_param: directed and random checks of rf_stage_param against a behavioural model
module tb_rf_stage_param;
  import rf_stage_pkg::*;
  localparam int DW = 16, RW = 5, FW = 8, OW = 6, PW = 16;
  localparam logic [PW-1:0] RPC = 16'h0000;
  logic clk = 1'b0, rst = 1'b0;
  logic mem_pipe_stall, flush1, PCupdate, bubble, pipe_stall;
  logic [PW-1:0] EXE_targetPC, fetch_pc;
  logic [RW-1:0] wb_wr_id;
  logic [DW-1:0] wb_result;
  logic [FW-1:0] wb_fmask, wb_flags;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  rf_stage_if #(.DATA_W(DW), .REG_ID_W(RW), .FLAG_W(FW), .OPC_W(OW), .PC_W(PW)) rf();
  rf_stage_param #(.DATA_W(DW), .REG_ID_W(RW), .FLAG_W(FW), .OPC_W(OW), .PC_W(PW), .RESET_PC(RPC)) dut (
    .CLK(clk), .RST(rst), .rf(rf),
    .mem_pipe_stall(mem_pipe_stall), .flush1(flush1), .PCupdate(PCupdate), .EXE_targetPC(EXE_targetPC),
    .wb_wr_id(wb_wr_id), .wb_result(wb_result), .wb_fmask(wb_fmask), .wb_flags(wb_flags),
    .fetch_pc(fetch_pc), .bubble(bubble), .pipe_stall(pipe_stall)
  );
  always #5 clk = ~clk;
  rf_fields_t m;
  logic [PW-1:0] m_pc;
  logic [DW-1:0] m_regs [32];
  logic [FW-1:0] m_flags;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] m_read(logic [RW-1:0] id);
    if (id == 0) return '0;
`ifdef RF_BYPASS_EN
    if (id == wb_wr_id) return wb_result;
`endif
    return m_regs[id];
  endfunction
  function automatic logic [FW-1:0] m_fread();
    logic [FW-1:0] f;
    f = m_flags;
`ifdef RF_BYPASS_EN
    for (int i = 0; i < FW; i++) if (wb_fmask[i]) f[i] = wb_flags[i];
`endif
    return f;
  endfunction
  function automatic logic m_bubble();
    logic b;
    b = rf.in_valid && m.valid && ((m.wr_id != 0 && (m.wr_id == rf.in_rd0_id || m.wr_id == rf.in_rd1_id))
                                   || (m.fmask != 0 && rf.in_fread));
`ifndef RF_BYPASS_EN
    if (rf.in_valid && wb_wr_id != 0 && (wb_wr_id == rf.in_rd0_id || wb_wr_id == rf.in_rd1_id)) b = 1'b1;
    if (wb_fmask != 0 && rf.in_fread) b = 1'b1;
`endif
    return b;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m <= '0;
      m_pc <= RPC;
      m_flags <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
    end else begin
      if (flush1) m.valid <= 1'b0;
      else if (mem_pipe_stall) ;
      else if (m_bubble()) begin
        m.valid <= 1'b0;
        m.wr_id <= '0;
        m.fmask <= '0;
      end else
        m <= '{valid: rf.in_valid, opcode: rf.in_opcode, wr_id: rf.in_wr_id, fmask: rf.in_fmask,
               imm: rf.in_imm, eoi: rf.in_eoi, rd0_data: m_read(rf.in_rd0_id), rd0_id: rf.in_rd0_id,
               rd1_data: m_read(rf.in_rd1_id), rd1_id: rf.in_rd1_id, flags: m_fread(),
               seq_npc: m_pc + PW'(rf.in_len)};
      if (PCupdate) m_pc <= EXE_targetPC;
      else if (rf.in_valid && !(mem_pipe_stall || m_bubble())) m_pc <= m_pc + PW'(rf.in_len);
      if (wb_wr_id != 0) m_regs[wb_wr_id] <= wb_result;
      for (int i = 0; i < FW; i++) if (wb_fmask[i]) m_flags[i] <= wb_flags[i];
    end
  always @(negedge clk)
    if (chk_en) begin
      chk("valid", rf.out_valid, m.valid);
      chk("wr_id", rf.out_wr_id, m.wr_id);
      chk("fmask", rf.out_fmask, m.fmask);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("bubble", bubble, m_bubble());
      chk("pipe_stall", pipe_stall, mem_pipe_stall | m_bubble());
      if (m.valid) begin
        chk("opcode", rf.out_opcode, m.opcode);
        chk("imm", rf.out_imm, m.imm);
        chk("eoi", rf.out_eoi, m.eoi);
        chk("rd0_data", rf.out_rd0_data, m.rd0_data);
        chk("rd0_id", rf.out_rd0_id, m.rd0_id);
        chk("rd1_data", rf.out_rd1_data, m.rd1_data);
        chk("rd1_id", rf.out_rd1_id, m.rd1_id);
        chk("flags", rf.out_flags, m.flags);
        chk("seq_npc", rf.out_seq_npc, m.seq_npc);
      end
    end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    rf.in_valid = 0; rf.in_opcode = 0; rf.in_len = 0; rf.in_rd0_id = 0; rf.in_rd1_id = 0;
    rf.in_wr_id = 0; rf.in_fmask = 0; rf.in_fread = 0; rf.in_imm = 0; rf.in_eoi = 0;
    mem_pipe_stall = 0; flush1 = 0; PCupdate = 0; EXE_targetPC = 0;
    wb_wr_id = 0; wb_result = 0; wb_fmask = 0; wb_flags = 0;
  endtask
  task automatic instr(logic [OW-1:0] opc, logic [2:0] len, logic [RW-1:0] r0, logic [RW-1:0] r1,
                       logic [RW-1:0] w, logic [DW-1:0] imm);
    rf.in_valid = 1; rf.in_opcode = opc; rf.in_len = len; rf.in_rd0_id = r0; rf.in_rd1_id = r1;
    rf.in_wr_id = w; rf.in_fmask = 0; rf.in_fread = 0; rf.in_imm = imm; rf.in_eoi = 1;
  endtask
  initial begin
    idle();
    #1 rst = 1;
    #10 rst = 0;
    tick();
    chk("rst_valid", rf.out_valid, 0);
    chk("rst_pc", fetch_pc, 32'(RPC));
    chk("rst_wr_id", rf.out_wr_id, 0);
    chk("rst_rd0", rf.out_rd0_data, 0);
    chk("rst_flags", rf.out_flags, 0);
    chk("rst_npc", rf.out_seq_npc, 0);
    chk_en = 1;
    instr(6'h01, 3'd2, 0, 0, 3, 16'h0);
    tick();
    chk("raw_exe_wr", rf.out_wr_id, 3);
    instr(6'h02, 3'd1, 0, 3, 4, 16'h0);
    wb_wr_id = 3; wb_result = 16'h1234;
    #1 chk("raw_bubble", bubble, 1);
    tick();
    chk("raw_pc_held", fetch_pc, 16'h0002);
    chk("raw_bub_valid", rf.out_valid, 0);
    wb_wr_id = 0;
    #1 chk("raw_bubble_clr", bubble, 0);
    tick();
    chk("raw_operand", rf.out_rd1_data, 16'h1234);
    chk("raw_valid", rf.out_valid, 1);
    chk("raw_pc", fetch_pc, 16'h0003);
    instr(6'h03, 3'd1, 5, 0, 0, 16'h0);
    wb_wr_id = 5; wb_result = 16'hBEEF;
`ifdef RF_BYPASS_EN
    #1 chk("byp_bubble", bubble, 0);
    tick();
`else
    #1 chk("byp_bubble", bubble, 1);
    tick();
    wb_wr_id = 0;
    #1 chk("byp_bubble_clr", bubble, 0);
    tick();
`endif
    chk("byp_rd0", rf.out_rd0_data, 16'hBEEF);
    wb_wr_id = 0;
    instr(6'h2A, 3'd2, 0, 0, 0, 16'h5555);
    tick();
    chk("fl_pre_opc", rf.out_opcode, 6'h2A);
    instr(6'h15, 3'd1, 0, 0, 0, 16'hAAAA);
    mem_pipe_stall = 1; flush1 = 1;
    tick();
    chk("fl_valid", rf.out_valid, 0);
    chk("fl_opc_held", rf.out_opcode, 6'h2A);
    chk("fl_imm_held", rf.out_imm, 16'h5555);
    chk("fl_pc_held", fetch_pc, 16'h0006);
    flush1 = 0;
    PCupdate = 1; EXE_targetPC = 16'h0100;
    tick();
    chk("redirect_pc", fetch_pc, 16'h0100);
    idle();
    PCupdate = 1; EXE_targetPC = 16'hFFFE;
    tick();
    PCupdate = 0;
    instr(6'h06, 3'd3, 0, 0, 0, 16'h0);
    tick();
    chk("wrap_pc", fetch_pc, 16'h0001);
    chk("wrap_npc", rf.out_seq_npc, 16'h0001);
    chk("mid_rst_pre", rf.out_valid, 1);
    #1 rst = 1;
    #1 chk("mid_rst_valid", rf.out_valid, 0);
    chk("mid_rst_pc", fetch_pc, 32'(RPC));
    rst = 0;
    for (int c = 0; c < 600; c++) begin
      rf.in_valid = $urandom_range(0, 3) != 0;
      rf.in_opcode = OW'($urandom);
      rf.in_len = 3'($urandom);
      rf.in_rd0_id = RW'($urandom_range(0, 7));
      rf.in_rd1_id = RW'($urandom_range(0, 7));
      rf.in_wr_id = RW'($urandom_range(0, 7));
      rf.in_fmask = ($urandom_range(0, 3) == 0) ? FW'($urandom) : '0;
      rf.in_fread = $urandom_range(0, 3) == 0;
      rf.in_imm = DW'($urandom);
      rf.in_eoi = 1'($urandom);
      mem_pipe_stall = $urandom_range(0, 6) == 0;
      flush1 = $urandom_range(0, 9) == 0;
      PCupdate = $urandom_range(0, 11) == 0;
      EXE_targetPC = PW'($urandom);
      wb_wr_id = $urandom_range(0, 1) ? RW'($urandom_range(1, 7)) : '0;
      wb_result = DW'($urandom);
      wb_fmask = ($urandom_range(0, 2) == 0) ? FW'($urandom) : '0;
      wb_flags = FW'($urandom);
      tick();
    end
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
